// File: rtl/decode_queue.sv
// decode_queue: show-ahead instruction queue between fetch and decode.
// Holds pc, instruction and fetch exception info; head computes npc.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AFULL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [31:0]                push_instr,
    input  logic                       push_exception,
    input  logic [3:0]                 push_ecause,
    input  logic [XLEN-1:0]            push_etval,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [XLEN-1:0]            pop_pc,
    output logic [XLEN-1:0]            pop_npc,
    output logic [31:0]                pop_instr,
    output logic                       pop_exception,
    output logic [3:0]                 pop_ecause,
    output logic [XLEN-1:0]            pop_etval,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            exc;
        logic [3:0]      ecause;
        logic [XLEN-1:0] etval;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rp;
    logic [AW-1:0]   wp;
    logic            full;
    logic            push_fire;
    logic            pop_fire;

    assign full        = (count == CW'(DEPTH));
    assign push_ready  = !full;
    assign pop_valid   = (count != '0);
    assign almost_full = (count >= CW'(AFULL));
    assign push_fire   = push_valid & push_ready;
    assign pop_fire    = pop_valid & pop_ready;

    // Pointer and occupancy bookkeeping; flush wins over any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else if (flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push_fire) wp <= wp + 1'b1;
            if (pop_fire)  rp <= rp + 1'b1;
            if (push_fire && !pop_fire)
                count <= count + 1'b1;
            else if (pop_fire && !push_fire)
                count <= count - 1'b1;
        end
    end

    // Entry storage; payload needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            mem[wp] <= '{pc:     push_pc,
                         instr:  push_instr,
                         exc:    push_exception,
                         ecause: push_ecause,
                         etval:  push_etval};
        end
    end

    // Head presentation with RVC-aware next pc.
    always_comb begin
        head          = mem[rp];
        pop_pc        = head.pc;
        pop_instr     = head.instr;
        pop_exception = head.exc;
        pop_ecause    = head.ecause;
        pop_etval     = head.etval;
        pop_npc       = head.pc + ((head.instr[1:0] == 2'b11) ?
                                   XLEN'(4) : XLEN'(2));
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed stimulus with a scoreboard monitor
// comparing every popped head against the queued expectations.
module tb_decode_queue;

    logic        clk = 0;
    logic        rst;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        push_exception;
    logic [3:0]  push_ecause;
    logic [31:0] push_etval;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_pc;
    logic [31:0] pop_npc;
    logic [31:0] pop_instr;
    logic        pop_exception;
    logic [3:0]  pop_ecause;
    logic [31:0] pop_etval;
    logic [2:0]  count;
    logic        almost_full;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  ecause;
        logic [31:0] etval;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] cur_npc;
    int          n_cmp = 0;
    int          n_fail = 0;

    decode_queue #(.DEPTH(4), .XLEN(32), .AFULL(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_pc(push_pc), .push_instr(push_instr),
        .push_exception(push_exception), .push_ecause(push_ecause),
        .push_etval(push_etval),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_pc(pop_pc), .pop_npc(pop_npc), .pop_instr(pop_instr),
        .pop_exception(pop_exception), .pop_ecause(pop_ecause),
        .pop_etval(pop_etval),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops happen at the next edge when seen here.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (pop_valid && pop_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pop", {32'd0, pop_pc}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_pc", {32'd0, pop_pc}, {32'd0, e.pc});
                    chk("sb_npc", {32'd0, pop_npc}, {32'd0, e.npc});
                    chk("sb_instr", {32'd0, pop_instr}, {32'd0, e.instr});
                    chk("sb_exc", {63'd0, pop_exception}, {63'd0, e.exc});
                    chk("sb_ecause", {60'd0, pop_ecause}, {60'd0, e.ecause});
                    chk("sb_etval", {32'd0, pop_etval}, {32'd0, e.etval});
                end
            end
            if (push_valid && push_ready) begin
                exp_t n;
                n.pc = push_pc;
                n.npc = cur_npc;
                n.instr = push_instr;
                n.exc = push_exception;
                n.ecause = push_ecause;
                n.etval = push_etval;
                sbq.push_back(n);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] npc);
        push_valid = 1;
        push_pc = pc;
        push_instr = ins;
        push_exception = 0;
        push_ecause = 0;
        push_etval = 0;
        cur_npc = npc;
    endtask

    initial begin
        rst = 1; flush = 0; push_valid = 0; pop_ready = 0;
        push_pc = 0; push_instr = 0; push_exception = 0;
        push_ecause = 0; push_etval = 0; cur_npc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_pop_valid", {63'd0, pop_valid}, 64'd0);
        chk("rst_push_ready", {63'd0, push_ready}, 64'd1);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_afull", {63'd0, almost_full}, 64'd0);

        // Two pushes, head presentation, one pop.
        tick;
        drive(32'h100, 32'h00000013, 32'h104);
        tick;
        drive(32'h104, 32'h00004501, 32'h106);
        tick;
        push_valid = 0;
        chk("t2_pc", {32'd0, pop_pc}, 64'h100);
        chk("t2_npc", {32'd0, pop_npc}, 64'h104);
        chk("t2_count", {61'd0, count}, 64'd2);
        pop_ready = 1;
        tick;
        pop_ready = 0;
        chk("t2_pc2", {32'd0, pop_pc}, 64'h104);
        chk("t2_npc2", {32'd0, pop_npc}, 64'h106);
        pop_ready = 1;
        tick;
        pop_ready = 0;
        chk("t2_empty", {63'd0, pop_valid}, 64'd0);

        // Fill to full; held push vs. same-cycle pop.
        for (int i = 0; i < 4; i++) begin
            drive(32'h300 + 32'(4 * i), 32'h00000013, 32'h304 + 32'(4 * i));
            tick;
        end
        drive(32'h310, 32'h00000013, 32'h314);
        chk("full_push_ready", {63'd0, push_ready}, 64'd0);
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_afull", {63'd0, almost_full}, 64'd1);
        pop_ready = 1;
        tick;
        pop_ready = 0;
        chk("full_pop_count", {61'd0, count}, 64'd3);
        chk("full_pop_ready", {63'd0, push_ready}, 64'd1);
        chk("full_pop_head", {32'd0, pop_pc}, 64'h304);
        tick;
        push_valid = 0;
        chk("refill_count", {61'd0, count}, 64'd4);
        pop_ready = 1;
        repeat (4) tick;
        pop_ready = 0;
        chk("drain_count", {61'd0, count}, 64'd0);

        // Steady state push+pop across pointer wrap.
        drive(32'h400, 32'h00000013, 32'h404);
        tick;
        drive(32'h404, 32'h00000001, 32'h406);
        tick;
        pop_ready = 1;
        for (int i = 0; i < 10; i++) begin
            drive(32'h408 + 32'(4 * i), 32'h00000013, 32'h40C + 32'(4 * i));
            tick;
            chk("steady_count", {61'd0, count}, 64'd2);
        end
        push_valid = 0;
        repeat (2) tick;
        pop_ready = 0;
        chk("steady_empty", {61'd0, count}, 64'd0);

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(4 * i), 32'h00000013, 32'h504 + 32'(4 * i));
            tick;
        end
        chk("pre_flush_count", {61'd0, count}, 64'd3);
        drive(32'h5FC, 32'h00000013, 32'h600);
        flush = 1;
        sbq.delete();
        tick;
        flush = 0;
        push_valid = 0;
        chk("flush_count", {61'd0, count}, 64'd0);
        chk("flush_pop_valid", {63'd0, pop_valid}, 64'd0);
        drive(32'h600, 32'h00000013, 32'h604);
        tick;
        push_valid = 0;
        chk("post_flush_head", {32'd0, pop_pc}, 64'h600);
        pop_ready = 1;
        tick;
        pop_ready = 0;

        // Exception entry and npc wrap.
        drive(32'h700, 32'h00000013, 32'h704);
        push_exception = 1;
        push_ecause = 4'd1;
        push_etval = 32'h200;
        tick;
        push_valid = 0;
        push_exception = 0;
        chk("exc_valid", {63'd0, pop_valid}, 64'd1);
        chk("exc_flag", {63'd0, pop_exception}, 64'd1);
        chk("exc_cause", {60'd0, pop_ecause}, 64'd1);
        chk("exc_etval", {32'd0, pop_etval}, 64'h200);
        pop_ready = 1;
        drive(32'hFFFFFFFE, 32'h00000013, 32'h00000002);
        tick;
        push_valid = 0;
        pop_ready = 0;
        chk("wrap_npc", {32'd0, pop_npc}, 64'h2);
        pop_ready = 1;
        tick;
        pop_ready = 0;

        // Asynchronous reset mid-cycle.
        drive(32'h800, 32'h00000013, 32'h804);
        tick;
        drive(32'h804, 32'h00000013, 32'h808);
        tick;
        push_valid = 0;
        chk("pre_rst_count", {61'd0, count}, 64'd2);
        #2 rst = 1;
        sbq.delete();
        #1;
        chk("async_rst_count", {61'd0, count}, 64'd0);
        chk("async_rst_valid", {63'd0, pop_valid}, 64'd0);
        chk("async_rst_ready", {63'd0, push_ready}, 64'd1);
        tick;
        rst = 0;
        tick;
        chk("post_rst_count", {61'd0, count}, 64'd0);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction queue between fetch and decode; successor to the single-register fetch/decode hand-off.
- Buffers up to DEPTH fetched instructions with their pc and exception info, so a decode stall no longer back-pressures fetch on the same cycle.
- Computes npc per entry (RVC-aware) and supports a single-cycle flush on jump/clear.
- Show-ahead FIFO: the head entry is always presented to decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of pc, npc and etval.
- AFULL, 3, almost_full asserts when count >= AFULL; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  discard all entries (decode jump or execute clear).
- push_valid  input  1  fetch presents an instruction.
- push_ready  output  1  queue accepts the instruction; equals !full.
- push_pc  input  XLEN  instruction pc.
- push_instr  input  32  instruction word (low 16 bits significant when [1:0] != 2'b11).
- push_exception  input  1  fetch exception flag.
- push_ecause  input  4  exception cause.
- push_etval  input  XLEN  exception value.
- pop_valid  output  1  head entry valid (!empty).
- pop_ready  input  1  decode consumes head (= !(decode stall | execute stall)).
- pop_pc  output  XLEN  head pc.
- pop_npc  output  XLEN  head pc + 4 if instr[1:0] == 2'b11, else pc + 2; modulo 2^XLEN.
- pop_instr  output  32  head instruction.
- pop_exception  output  1  head exception flag.
- pop_ecause  output  4  head cause.
- pop_etval  output  XLEN  head etval.
- count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL.

Behaviour:
- Storage: DEPTH-entry array. Read pointer rp and write pointer wp, each clog2(DEPTH) bits, wrap naturally. count is held separately.
- Reset, asynchronous on rst high:
  - rp = wp = count = 0.
  - pop_valid = 0, push_ready = 1, almost_full = 0.
  - Data array is not reset. Data outputs are don't-care while pop_valid = 0, but the bench must not see X on pop_valid, push_ready, count or almost_full.
- Transfers:
  - push fires when push_valid & push_ready.
  - pop fires when pop_valid & pop_ready.
  - Both are evaluated on the same edge.
- Push: writes entry[wp], then wp <= wp+1.
- Pop: rp <= rp+1.
- Count update: push only +1, pop only -1, both 0.
- Latency: no bypass. An instruction pushed at edge N is first visible on pop_* after edge N, i.e. one cycle push-to-pop.
- Head outputs: pop_* are driven combinationally from entry[rp]. pop_npc is combinational from the head pc and instr.
- Full (count == DEPTH):
  - push_ready = 0, even if pop fires the same cycle; no pass-through when full.
  - push_valid is ignored and fetch must hold.
- Empty (count == 0):
  - pop_valid = 0 and pop_ready is ignored.
  - A push to an empty queue is visible next cycle.
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
- Flush has priority over push and pop on the same edge: rp <= 0, wp <= 0, count <= 0, and any push that cycle is dropped. push_ready is not gated by flush; fetch must discard its own request.
- After flush: pop_valid = 0 the following cycle.
- Exception entries are queued like normal entries; the queue does not interpret them.
- pop_ready may toggle freely. Head data stays stable while pop_valid & !pop_ready.
- Reset mid-operation clears state immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle → pop_valid=0, push_ready=1, count=0, almost_full=0. Assert rst asynchronously mid-cycle after 2 pushes → count=0 before the next edge.
- DEPTH=4: push pc 0x100 instr 0x00000013, then pc 0x104 instr 0x4501 with pop_ready=0.
  - pop_pc=0x100, pop_npc=0x104, count=2.
  - Pop once → pop_pc=0x104, pop_npc=0x106.
- Fill 4 entries with pop_ready=0 → push_ready=0, count=4, almost_full=1 (AFULL=3). A fifth push_valid is held. Then pop and push on the same cycle:
  - The pop is accepted and the push is not.
  - Next cycle count=3 and push_ready=1.
- Steady state, count=2, push and pop every cycle for 10 cycles → count stays 2, output order matches input order across pointer wrap.
- count=3, assert flush with push_valid=1 → next cycle count=0, pop_valid=0. The flushed-cycle instruction never appears at pop.
- Push an entry with exception=1, ecause=1, etval=0x200 → the same values appear on pop_* with pop_valid=1. pc=0xFFFFFFFE with instr 0x00000013 → pop_npc=0x00000002 (wrap).
